// File: rtl/xor_stream_decrypt_if.sv
// Stream and key-control bundle between the link receive buffer, the
// decryptor and the plaintext consumer.
interface xor_stream_decrypt_if #(
    parameter int DATA_W = 32
);
    logic              key_load;
    logic [DATA_W-1:0] key_in;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              keyed;
    logic [15:0]       word_cnt;

    modport master (
        output key_load, key_in, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, keyed, word_cnt
    );

    modport slave (
        input  key_load, key_in, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, keyed, word_cnt
    );
endinterface

// File: rtl/xor_stream_decrypt.sv
// Receive-side XOR stream decryptor: ciphertext ^ Galois LFSR keystream,
// one registered output word, LFSR steps once per accepted word.
module xor_stream_decrypt #(
    parameter int          DATA_W       = 32,
    parameter logic [31:0] POLY         = 32'h04C11DB7,
    parameter logic [31:0] SEED_DEFAULT = 32'hACE1ACE1
) (
    input logic                 clk,
    input logic                 rst_n,
    xor_stream_decrypt_if.slave bus
);

    typedef enum logic {
        UNKEYED = 1'b0,
        KEYED   = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DATA_W-1:0]  ks;
    logic [DATA_W-1:0]  out_data_p1;
    logic               vld_p1;
    logic [15:0]        word_cnt;
    logic               keyed;
    logic               in_ready;
    logic               accept;

    // A zero seed would lock the LFSR at zero forever, so it is replaced.
    function automatic logic [DATA_W-1:0] seed_sel(input logic [DATA_W-1:0] key);
        seed_sel = (key == '0) ? SEED_DEFAULT : key;
    endfunction

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] cur);
        lfsr_step = {cur[DATA_W-2:0], 1'b0} ^ (cur[DATA_W-1] ? POLY : '0);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNKEYED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.key_load) begin
            state_d = KEYED;
        end
    end

    assign keyed    = (state_q == KEYED);
    // key_load blocks acceptance so no word is ever encrypted with a half-switched key.
    assign in_ready = keyed && !bus.key_load && (!vld_p1 || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks       <= SEED_DEFAULT;
            word_cnt <= '0;
        end else if (bus.key_load) begin
            ks       <= seed_sel(bus.key_in);
            word_cnt <= '0;
        end else if (accept) begin
            ks       <= lfsr_step(ks);
            word_cnt <= word_cnt + 16'd1;
        end
    end

    // Stage p1: registered plaintext word and its valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_p1 <= '0;
            vld_p1      <= 1'b0;
        end else if (accept) begin
            out_data_p1 <= bus.in_data ^ ks;
            vld_p1      <= 1'b1;
        end else if (vld_p1 && bus.out_ready) begin
            vld_p1      <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = out_data_p1;
    assign bus.keyed     = keyed;
    assign bus.word_cnt  = word_cnt;

endmodule

// File: tb/tb_xor_stream_decrypt.sv
// Directed bench for xor_stream_decrypt: keystream vectors, backpressure,
// key_load interaction and asynchronous reset.
module tb_xor_stream_decrypt;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    xor_stream_decrypt_if #(.DATA_W(32)) bus ();

    xor_stream_decrypt dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [31:0] k);
        bus.key_load = 1'b1;
        bus.key_in   = k;
        cycle();
        bus.key_load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.key_load = 1'b0;
        bus.key_in   = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        repeat (3) cycle();
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
        end
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            fails++; $display("FAIL reset_out got v=%b d=%h want v=0 d=0", bus.out_valid, bus.out_data);
        end
        tests++;
        if (bus.keyed !== 1'b0 || bus.word_cnt !== 16'h0) begin
            fails++; $display("FAIL reset_keyed_cnt got k=%b c=%h want 0/0", bus.keyed, bus.word_cnt);
        end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_unkeyed();
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEADBEEF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (bus.in_ready !== 1'b0 || bus.keyed !== 1'b0 || bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL unkeyed_idle cyc %0d got rdy=%b k=%b v=%b want 0/0/0",
                         i, bus.in_ready, bus.keyed, bus.out_valid);
            end
            cycle();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_key_one();
        bus.out_ready = 1'b1;
        bus.key_load  = 1'b1;
        bus.key_in    = 32'h00000001;
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL keyload_blocks_ready got %b want 0", bus.in_ready);
        end
        cycle();
        bus.key_load = 1'b0;
        tests++;
        if (bus.keyed !== 1'b1 || bus.word_cnt !== 16'd0) begin
            fails++; $display("FAIL keyed_after_load got k=%b c=%0d want 1/0", bus.keyed, bus.word_cnt);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hFFFFFFFF;
        cycle();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFFFFFE) begin
            fails++; $display("FAIL key1_word0 got v=%b d=%h want 1/fffffffe", bus.out_valid, bus.out_data);
        end
        bus.in_data = 32'h00000000;
        cycle();
        bus.in_valid = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00000002) begin
            fails++; $display("FAIL key1_word1 got v=%b d=%h want 1/00000002", bus.out_valid, bus.out_data);
        end
        tests++;
        if (bus.word_cnt !== 16'd2) begin
            fails++; $display("FAIL key1_cnt got %0d want 2", bus.word_cnt);
        end
        cycle();
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL key1_drain got v=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_key_msb();
        load_key(32'h80000000);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0;
        cycle();
        tests++;
        if (bus.out_data !== 32'h80000000) begin
            fails++; $display("FAIL msb_word0 got %h want 80000000", bus.out_data);
        end
        cycle();
        bus.in_valid = 1'b0;
        tests++;
        if (bus.out_data !== 32'h04C11DB7) begin
            fails++; $display("FAIL msb_word1_poly got %h want 04c11db7", bus.out_data);
        end
        cycle();
    endtask

    task automatic test_zero_key();
        load_key(32'h0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h12345678;
        cycle();
        bus.in_valid = 1'b0;
        // ACE1ACE1 ^ 12345678
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hBED5FA99) begin
            fails++; $display("FAIL zero_key_default got v=%b d=%h want 1/bed5fa99", bus.out_valid, bus.out_data);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        load_key(32'h00000001);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h00000010;
        cycle();
        bus.in_data = 32'h00000020;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 32'h00000011
                || bus.word_cnt !== 16'd1) begin
                fails++;
                $display("FAIL stall_hold cyc %0d got rdy=%b v=%b d=%h c=%0d want 0/1/00000011/1",
                         i, bus.in_ready, bus.out_valid, bus.out_data, bus.word_cnt);
            end
            cycle();
        end
        bus.out_ready = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL stall_release_ready got %b want 1", bus.in_ready);
        end
        cycle();
        bus.in_valid = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00000022 || bus.word_cnt !== 16'd2) begin
            fails++; $display("FAIL same_cycle_xfer got v=%b d=%h c=%0d want 1/00000022/2",
                              bus.out_valid, bus.out_data, bus.word_cnt);
        end
        cycle();
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_drain got v=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_keyload_and_reset();
        load_key(32'h00000003);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h00000100;
        cycle();
        bus.in_valid = 1'b0;
        // rekey while a word is pending and stalled
        bus.key_load = 1'b1;
        bus.key_in   = 32'h00000077;
        cycle();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00000103 || bus.word_cnt !== 16'd0) begin
            fails++; $display("FAIL rekey_pending got v=%b d=%h c=%0d want 1/00000103/0",
                              bus.out_valid, bus.out_data, bus.word_cnt);
        end
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h00000200;
        bus.out_ready = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL keyload_with_valid_ready got %b want 0", bus.in_ready);
        end
        cycle();
        bus.key_load = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.word_cnt !== 16'd0) begin
            fails++; $display("FAIL keyload_no_accept got v=%b c=%0d want 0/0", bus.out_valid, bus.word_cnt);
        end
        bus.out_ready = 1'b0;
        cycle();
        tests++;
        if (bus.out_data !== 32'h00000277 || bus.word_cnt !== 16'd1) begin
            fails++; $display("FAIL new_key_applies got d=%h c=%0d want 00000277/1", bus.out_data, bus.word_cnt);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.keyed !== 1'b0
            || bus.word_cnt !== 16'd0 || bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL async_reset got v=%b d=%h k=%b c=%0d r=%b want all 0",
                              bus.out_valid, bus.out_data, bus.keyed, bus.word_cnt, bus.in_ready);
        end
        bus.in_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_unkeyed();
        test_key_one();
        test_key_msb();
        test_zero_key();
        test_back_to_back();
        test_keyload_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
